// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store datapath: op encodings, FSM states and
// the read-latency counter width.
package store_pkg;

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;

  // Holds READ_LAT-1 for READ_LAT in 1..4
  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic logic store_misaligned(input logic [1:0] op,
                                            input logic [1:0] lane);
    case (op)
      OP_SW:   return (lane != 2'b00);
      OP_SH:   return lane[0];
      OP_SB:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Little-endian sub-word merge: splices store data into the old memory word
// at the lane selected by the low address bits.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  op,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (op)
      OP_SB: begin
        case (lane)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = old_word;
        endcase
      end
      OP_SH: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store read-modify-write sequencer for sw/sh/sb against a word-addressed
// data memory with configurable read latency.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t            state;
  logic [1:0]        op_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       merged;

  store_lane_merge u_lane_merge (
    .old_word (mem_rdata),
    .wdata    (wdata_q),
    .op       (op_q),
    .lane     (addr_q[1:0]),
    .merged   (merged)
  );

  // Derived from the latched address register, so still a registered output
  assign mem_addr = {addr_q[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
            if (store_misaligned(op, addr[1:0])) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (op == OP_SW) begin
              state     <= S_WRITE;
              mem_wr    <= 1'b1;
              mem_wdata <= wdata;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          state <= S_WAIT;
          cnt   <= CNT_W'(READ_LAT - 1);
        end
        S_WAIT: begin
          // Final WAIT edge: capture the read word already merged
          if (cnt == '0) begin
            state     <= S_WRITE;
            mem_wr    <= 1'b1;
            mem_wdata <= merged;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WRITE: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
